// File: rtl/out_channel_checker.sv
// Out-channel checker: loads a table of expected words, then compares the words the
// program emits against it in order and reports finished/success plus first-failure details.
module out_channel_checker #(
  parameter int WIDTH   = 12,
  parameter int NEXPECT = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024,
  parameter int TIMER_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ready,
  input  logic             prog_done,
  output logic             finished,
  output logic             success,
  output logic             mismatch,
  output logic             overflow,
  output logic             timeout,
  output logic [CNT_W-1:0] recv_count,
  output logic [CNT_W-1:0] fail_index,
  output logic [WIDTH-1:0] fail_got,
  output logic [WIDTH-1:0] fail_exp
);

  localparam int IDX_W = (NEXPECT > 1) ? $clog2(NEXPECT) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0]   NEXP_C  = CNT_W'(NEXPECT);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [TIMER_W-1:0] TLAST   = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, stateNext;
  logic [WIDTH-1:0]   expTable [DEPTH];
  logic [CNT_W-1:0]   loadCnt, loadCntNext;
  logic [TIMER_W-1:0] timer;
  logic [WIDTH-1:0]   tableWord;
  logic               loadFire, outFire, inRange, mismatchHit, overflowHit, firstFail;

  // load_ready/out_ready are registered copies of the state, so they gate the handshakes
  assign loadFire    = load_valid && load_ready;
  assign outFire     = out_valid && out_ready;
  assign loadCntNext = loadCnt + CNT_W'(loadFire);
  assign tableWord   = expTable[recv_count[IDX_W-1:0]];
  assign inRange     = recv_count < loadCnt;
  assign mismatchHit = outFire && inRange && (out_data != tableWord);
  assign overflowHit = outFire && !inRange;
  assign firstFail   = (mismatchHit || overflowHit) && !mismatch && !overflow;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (prog_done || timer == TLAST) stateNext = DONE;
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Expected-value storage survives reset; only the fill pointer is cleared
  always_ff @(posedge clock) begin
    if (loadFire) expTable[loadCnt[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loadCnt    <= '0;
      timer      <= '0;
      load_ready <= 1'b0;
      out_ready  <= 1'b0;
      finished   <= 1'b0;
      success    <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      recv_count <= '0;
      fail_index <= '0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          loadCnt <= loadCntNext;
          if (start) begin
            recv_count <= '0;
            mismatch   <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            fail_index <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
            timer      <= '0;
            load_ready <= 1'b0;
            out_ready  <= 1'b1;
          end else begin
            load_ready <= loadCntNext < NEXP_C;
          end
        end
        RUN: begin
          load_ready <= 1'b0;
          timer      <= timer + TIMER_W'(1);
          if (outFire) begin
            if (recv_count != CNT_MAX) recv_count <= recv_count + CNT_W'(1);
            if (mismatchHit) mismatch <= 1'b1;
            if (overflowHit) overflow <= 1'b1;
            if (firstFail) begin
              fail_index <= recv_count;
              fail_got   <= out_data;
              fail_exp   <= inRange ? tableWord : '0;
            end
          end
          // prog_done has priority over an expiring timer in the same cycle
          if (stateNext == DONE) begin
            out_ready <= 1'b0;
            if (!prog_done) timeout <= 1'b1;
          end
        end
        DONE: begin
          out_ready <= 1'b0;
          finished  <= 1'b1;
          success   <= !mismatch && !overflow && !timeout && (recv_count == loadCnt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: directed cases plus randomized runs checked against a
// list-based model of the expected words and the words sent.
module tb_out_channel_checker;
  localparam int WIDTH = 12, NEXPECT = 8, CNT_W = 8, TIMEOUT = 16, TIMER_W = 16;

  logic             clock = 1'b0, reset = 1'b1;
  logic             load_valid = 1'b0, start = 1'b0, out_valid = 1'b0, prog_done = 1'b0;
  logic [WIDTH-1:0] load_data = '0, out_data = '0;
  logic             load_ready, out_ready, finished, success, mismatch, overflow, timeout;
  logic [CNT_W-1:0] recv_count, fail_index;
  logic [WIDTH-1:0] fail_got, fail_exp;

  int errors = 0, checks = 0;
  logic [WIDTH-1:0] loadQ[$], sendQ[$];

  out_channel_checker #(.WIDTH(WIDTH), .NEXPECT(NEXPECT), .CNT_W(CNT_W),
                        .TIMEOUT(TIMEOUT), .TIMER_W(TIMER_W)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .prog_done(prog_done), .finished(finished), .success(success),
    .mismatch(mismatch), .overflow(overflow), .timeout(timeout), .recv_count(recv_count),
    .fail_index(fail_index), .fail_got(fail_got), .fail_exp(fail_exp));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitFinished(input string name);
    for (int c = 0; c < 40 && finished !== 1'b1; c++) @(negedge clock);
    check({name, ".finished"}, 32'(finished), 32'd1);
  endtask

  // Full run: load loadQ, start, send sendQ, end by prog_done or by timeout, then compare
  task automatic runScenario(input string name, input bit useTimeout, input bit lastWithDone,
                             input bit startWithLoad);
    int offered, nAcc, nSent, fIdx;
    bit expMis, expOvf, found, expSucc;
    logic [WIDTH-1:0] fGot, fExp;
    doReset();
    offered = (startWithLoad && loadQ.size() > 0) ? loadQ.size() - 1 : loadQ.size();
    for (int i = 0; i < offered; i++) begin
      load_valid = 1'b1;
      load_data  = loadQ[i];
      @(negedge clock);
    end
    load_valid = 1'b0;
    check({name, ".loadReady"}, 32'(load_ready), 32'(offered < NEXPECT));
    start = 1'b1;
    if (offered < loadQ.size()) begin
      load_valid = 1'b1;
      load_data  = loadQ[offered];
    end
    @(negedge clock);
    start = 1'b0;
    load_valid = 1'b0;
    check({name, ".runOutReady"}, 32'(out_ready), 32'd1);
    check({name, ".runLoadReady"}, 32'(load_ready), 32'd0);
    for (int i = 0; i < sendQ.size(); i++) begin
      out_valid = 1'b1;
      out_data  = sendQ[i];
      start     = (i == 0);
      if (i == sendQ.size() - 1 && lastWithDone && !useTimeout) prog_done = 1'b1;
      @(negedge clock);
    end
    out_valid = 1'b0;
    start = 1'b0;
    if (!useTimeout && prog_done == 1'b0) begin
      prog_done = 1'b1;
      @(negedge clock);
    end
    prog_done = 1'b0;
    waitFinished(name);
    out_valid = 1'b1;
    out_data  = 12'hABC;
    @(negedge clock);
    out_valid = 1'b0;

    nAcc  = loadQ.size() < NEXPECT ? loadQ.size() : NEXPECT;
    nSent = sendQ.size();
    expMis = 0; expOvf = 0; found = 0; fIdx = 0; fGot = '0; fExp = '0;
    for (int i = 0; i < nSent; i++) begin
      if (i >= nAcc || sendQ[i] != loadQ[i]) begin
        if (i >= nAcc) expOvf = 1; else expMis = 1;
        if (!found) begin
          found = 1;
          fIdx  = i;
          fGot  = sendQ[i];
          fExp  = (i >= nAcc) ? '0 : loadQ[i];
        end
      end
    end
    expSucc = !expMis && !expOvf && !useTimeout && (nSent == nAcc);
    check({name, ".success"},   32'(success),    32'(expSucc));
    check({name, ".mismatch"},  32'(mismatch),   32'(expMis));
    check({name, ".overflow"},  32'(overflow),   32'(expOvf));
    check({name, ".timeout"},   32'(timeout),    32'(useTimeout));
    check({name, ".recvCount"}, 32'(recv_count), 32'(nSent));
    check({name, ".failIndex"}, 32'(fail_index), 32'(fIdx));
    check({name, ".failGot"},   32'(fail_got),   32'(fGot));
    check({name, ".failExp"},   32'(fail_exp),   32'(fExp));
    check({name, ".doneOutReady"}, 32'(out_ready), 32'd0);
  endtask

  initial begin
    int cyc, nLoad, nSend;
    bit useTo;
    @(negedge clock);
    check("reset.loadReady", 32'(load_ready), 32'd0);
    check("reset.finished",  32'(finished),   32'd0);

    loadQ = {12'd2, 12'd1}; sendQ = {12'd2, 12'd1};
    runScenario("pass", 0, 0, 0);
    loadQ = {12'd2, 12'd1}; sendQ = {12'd2, 12'd5};
    runScenario("mismatch", 0, 0, 0);
    loadQ = {12'd2, 12'd1}; sendQ = {12'd2, 12'd1, 12'd7};
    runScenario("overflow", 0, 1, 0);
    loadQ = {12'd2, 12'd1}; sendQ = {12'd2};
    runScenario("short", 0, 0, 0);
    loadQ = {12'd2, 12'd1}; sendQ = {12'd2, 12'd1};
    runScenario("startLoad", 0, 1, 1);
    loadQ = {}; sendQ = {};
    for (int i = 0; i < 10; i++) loadQ.push_back(WIDTH'(i * 37 + 5));
    for (int i = 0; i < 8; i++) sendQ.push_back(loadQ[i]);
    runScenario("tableFull", 0, 0, 0);

    doReset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (finished !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("timeout.cycles",  32'(cyc),     32'd17);
    check("timeout.flag",    32'(timeout), 32'd1);
    check("timeout.success", 32'(success), 32'd0);

    doReset();
    load_valid = 1'b1; load_data = 12'd2; @(negedge clock);
    load_data = 12'd1; @(negedge clock);
    load_valid = 1'b0;
    start = 1'b1; @(negedge clock);
    start = 1'b0;
    out_valid = 1'b1; out_data = 12'd2; @(negedge clock);
    out_valid = 1'b0;
    check("midRun.recvBefore", 32'(recv_count), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midRun.outs", {load_ready, out_ready, finished, success, mismatch, overflow, timeout,
                          recv_count, fail_index, fail_got, fail_exp} == '0, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("midRun.loadReady", 32'(load_ready), 32'd1);
    check("midRun.outReady",  32'(out_ready),  32'd0);
    start = 1'b1; @(negedge clock);
    start = 1'b0;
    prog_done = 1'b1; @(negedge clock);
    prog_done = 1'b0;
    waitFinished("emptyTable");
    check("emptyTable.success", 32'(success), 32'd1);
    check("emptyTable.recv",    32'(recv_count), 32'd0);

    for (int r = 0; r < 25; r++) begin
      loadQ = {}; sendQ = {};
      nLoad = $urandom_range(0, 10);
      nSend = $urandom_range(0, 10);
      for (int i = 0; i < nLoad; i++) loadQ.push_back(WIDTH'($urandom));
      for (int i = 0; i < nSend; i++)
        sendQ.push_back((i < nLoad && i < NEXPECT && $urandom_range(0, 3) != 0)
                        ? loadQ[i] : WIDTH'($urandom));
      useTo = ($urandom_range(0, 5) == 0);
      runScenario($sformatf("rand%0d", r), useTo, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
